// File: rtl/if_loader_ctrl_pkg.sv
// Shared constants for the instruction loader: bus widths, host command
// codes, the HALT instruction word and the controller state encoding.
package if_loader_ctrl_pkg;

  localparam int NB_INST   = 32;
  localparam int NB_ADDR   = 32;
  localparam int NB_DATA   = 8;
  localparam int MEM_DEPTH = 64;

  localparam logic [NB_DATA-1:0] CMD_LOAD = 8'h4C;
  localparam logic [NB_DATA-1:0] CMD_RUN  = 8'h52;
  localparam logic [NB_DATA-1:0] CMD_STEP = 8'h53;

  // An all-zero instruction word marks the end of a program image.
  localparam logic [NB_INST-1:0] HALT_WORD = '0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_RUN   = 3'd3,
    ST_STEP  = 3'd4
  } state_t;

endpackage

// File: rtl/if_loader_ctrl_word_assembler.sv
// Packs host bytes MSB-first into instruction words; word_done flags the
// byte that completes a word, with word_next presenting the full word.
module word_assembler #(
  parameter int NB_INST = if_loader_ctrl_pkg::NB_INST,
  parameter int NB_DATA = if_loader_ctrl_pkg::NB_DATA
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               byte_valid,
  input  logic [NB_DATA-1:0] data_in,
  output logic [NB_INST-1:0] word_next,
  output logic               word_done
);

  import if_loader_ctrl_pkg::*;

  localparam int         NB_SHIFT  = NB_INST - NB_DATA;
  localparam logic [1:0] LAST_BYTE = 2'(NB_INST / NB_DATA - 1);

  // Only the bytes before the final one need storing; the last byte is
  // spliced in combinationally so the word is ready on its arrival edge.
  logic [NB_SHIFT-1:0] shift_reg;
  logic [1:0]          byte_cnt;

  assign word_next = {shift_reg, data_in};
  assign word_done = byte_valid && (byte_cnt == LAST_BYTE);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shift_reg <= '0;
      byte_cnt  <= '0;
    end else if (byte_valid) begin
      shift_reg <= word_next[NB_SHIFT-1:0];
      byte_cnt  <= word_done ? 2'd0 : byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/if_loader_ctrl.sv
// Host-driven loader/run controller: streams a program into instruction
// memory, then runs or single-steps the pipeline until HALT retires.
module if_loader_ctrl #(
  parameter int NB_INST   = if_loader_ctrl_pkg::NB_INST,
  parameter int NB_ADDR   = if_loader_ctrl_pkg::NB_ADDR,
  parameter int NB_DATA   = if_loader_ctrl_pkg::NB_DATA,
  parameter int MEM_DEPTH = if_loader_ctrl_pkg::MEM_DEPTH
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic               o_rx_ready,
  input  logic               i_halt,
  output logic               o_write,
  output logic [NB_ADDR-1:0] o_address,
  output logic [NB_INST-1:0] o_instruction,
  output logic               o_enable,
  output logic               o_loaded,
  output logic               o_halted
);

  import if_loader_ctrl_pkg::*;

  localparam logic [NB_ADDR-1:0] LAST_IDX = NB_ADDR'(MEM_DEPTH - 1);

  state_t state;
  state_t next_state;

  logic               rx_accept;
  logic               load_start;
  logic               can_run;
  logic               write_last;
  logic               asm_valid;
  logic [NB_INST-1:0] word_next;
  logic               word_done;

  logic               rx_ready_d;
  logic               write_d;
  logic               enable_d;
  logic               loaded_d;
  logic               halted_d;
  logic [NB_ADDR-1:0] address_d;
  logic [NB_INST-1:0] instruction_d;

  assign rx_accept  = i_rx_valid && o_rx_ready;
  assign asm_valid  = rx_accept && (state == ST_LOAD);
  assign can_run    = o_loaded && !o_halted;
  assign write_last = (o_instruction == HALT_WORD) || (o_address == LAST_IDX);

  word_assembler #(
    .NB_INST (NB_INST),
    .NB_DATA (NB_DATA)
  ) u_word_assembler (
    .clk        (i_clk),
    .reset      (i_reset),
    .clear      (load_start),
    .byte_valid (asm_valid),
    .data_in    (i_rx_data),
    .word_next  (word_next),
    .word_done  (word_done)
  );

  // Every output is registered, so the next-cycle output values are derived
  // here together with the next state and captured alongside it.
  always_comb begin
    next_state    = state;
    load_start    = 1'b0;
    address_d     = o_address;
    instruction_d = o_instruction;
    loaded_d      = o_loaded;
    halted_d      = o_halted;

    case (state)
      ST_IDLE: begin
        if (rx_accept) begin
          if (i_rx_data == CMD_LOAD) begin
            next_state = ST_LOAD;
            load_start = 1'b1;
            address_d  = '0;
            loaded_d   = 1'b0;
            halted_d   = 1'b0;
          end else if ((i_rx_data == CMD_RUN) && can_run) begin
            next_state = ST_RUN;
          end else if ((i_rx_data == CMD_STEP) && can_run) begin
            next_state = ST_STEP;
          end
        end
      end
      ST_LOAD: begin
        if (word_done) begin
          next_state    = ST_WRITE;
          instruction_d = word_next;
        end
      end
      ST_WRITE: begin
        // The index saturates at the last word, so memory is never wrapped.
        if (write_last) begin
          loaded_d   = 1'b1;
          next_state = ST_IDLE;
        end else begin
          address_d  = o_address + NB_ADDR'(1);
          next_state = ST_LOAD;
        end
      end
      ST_RUN: begin
        if (i_halt) begin
          halted_d   = 1'b1;
          next_state = ST_IDLE;
        end
      end
      ST_STEP: begin
        if (i_halt) begin
          halted_d = 1'b1;
        end
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase

    rx_ready_d = (next_state == ST_IDLE) || (next_state == ST_LOAD);
    write_d    = (next_state == ST_WRITE);
    enable_d   = (next_state == ST_RUN) || (next_state == ST_STEP);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= ST_IDLE;
      o_rx_ready    <= 1'b0;
      o_write       <= 1'b0;
      o_enable      <= 1'b0;
      o_loaded      <= 1'b0;
      o_halted      <= 1'b0;
      o_address     <= '0;
      o_instruction <= '0;
    end else begin
      state         <= next_state;
      o_rx_ready    <= rx_ready_d;
      o_write       <= write_d;
      o_enable      <= enable_d;
      o_loaded      <= loaded_d;
      o_halted      <= halted_d;
      o_address     <= address_d;
      o_instruction <= instruction_d;
    end
  end

  // Write and enable come from disjoint states; the index never passes the end.
  assert property (@(posedge i_clk) disable iff (i_reset) !(o_write && o_enable));
  assert property (@(posedge i_clk) disable iff (i_reset) o_address <= LAST_IDX);

endmodule

// File: tb/tb_if_loader_ctrl.sv
// Randomized bench for if_loader_ctrl: a transaction-level model of the
// host protocol predicts memory writes, enable cycles and status flags.
`timescale 1ns/1ps
module tb_if_loader_ctrl;

  localparam int NB_INST   = 32;
  localparam int NB_ADDR   = 32;
  localparam int NB_DATA   = 8;
  localparam int MEM_DEPTH = 64;

  localparam logic [7:0] B_LOAD = 8'h4C;
  localparam logic [7:0] B_RUN  = 8'h52;
  localparam logic [7:0] B_STEP = 8'h53;

  logic               i_clk      = 1'b0;
  logic               i_reset    = 1'b1;
  logic [NB_DATA-1:0] i_rx_data  = '0;
  logic               i_rx_valid = 1'b0;
  logic               i_halt     = 1'b0;
  logic               o_rx_ready;
  logic               o_write;
  logic [NB_ADDR-1:0] o_address;
  logic [NB_INST-1:0] o_instruction;
  logic               o_enable;
  logic               o_loaded;
  logic               o_halted;

  if_loader_ctrl #(
    .NB_INST   (NB_INST),
    .NB_ADDR   (NB_ADDR),
    .NB_DATA   (NB_DATA),
    .MEM_DEPTH (MEM_DEPTH)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_rx_data     (i_rx_data),
    .i_rx_valid    (i_rx_valid),
    .o_rx_ready    (o_rx_ready),
    .i_halt        (i_halt),
    .o_write       (o_write),
    .o_address     (o_address),
    .o_instruction (o_instruction),
    .o_enable      (o_enable),
    .o_loaded      (o_loaded),
    .o_halted      (o_halted)
  );

  always #5 i_clk = ~i_clk;

  int check_count = 0;
  int error_count = 0;

  // Observed activity, sampled mid-cycle: writes as {address, word}.
  logic [63:0] got_writes[$];
  int          enable_total  = 0;
  int          overlap_total = 0;

  always @(negedge i_clk) begin
    if (o_write) got_writes.push_back({o_address, o_instruction});
    if (o_enable) enable_total++;
    if (o_write && o_enable) overlap_total++;
  end

  // Model state: is a program resident, and has it halted.
  bit model_loaded = 1'b0;
  bit model_halted = 1'b0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer one byte to the DUT and hold it until accepted (bounded wait).
  task automatic applyStimulus(input logic [7:0] b);
    int waited;
    i_halt = 1'($urandom);
    repeat ($urandom_range(0, 2)) @(negedge i_clk);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    waited     = 0;
    while (!o_rx_ready && waited < 40) begin
      @(negedge i_clk);
      waited++;
    end
    if (!o_rx_ready) checkOutput("rx_ready_timeout", o_rx_ready, 1);
    @(negedge i_clk);
    i_rx_valid = 1'b0;
    i_rx_data  = 8'($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_write"},       o_write,       0);
    checkOutput({tag, "_enable"},      o_enable,      0);
    checkOutput({tag, "_loaded"},      o_loaded,      0);
    checkOutput({tag, "_halted"},      o_halted,      0);
    checkOutput({tag, "_rx_ready"},    o_rx_ready,    0);
    checkOutput({tag, "_address"},     o_address,     0);
    checkOutput({tag, "_instruction"}, o_instruction, 0);
  endtask

  task automatic check_flags(input string tag);
    checkOutput({tag, "_loaded"},   o_loaded,   model_loaded);
    checkOutput({tag, "_halted"},   o_halted,   model_halted);
    checkOutput({tag, "_rx_ready"}, o_rx_ready, 1);
  endtask

  task automatic release_reset();
    i_reset      = 1'b0;
    model_loaded = 1'b0;
    model_halted = 1'b0;
    @(negedge i_clk);
  endtask

  // A program image ends at its first zero word or at the last memory slot.
  task automatic do_load(input logic [31:0] words[$]);
    logic [63:0] exp[$];
    int base_wr;
    int base_en;
    for (int i = 0; i < words.size(); i++) begin
      exp.push_back({32'(i), words[i]});
      if (words[i] == 32'h0 || i == MEM_DEPTH - 1) break;
    end
    base_wr = got_writes.size();
    base_en = enable_total;
    applyStimulus(B_LOAD);
    for (int i = 0; i < exp.size(); i++)
      for (int b = 3; b >= 0; b--) applyStimulus(exp[i][8*b +: 8]);
    repeat (3) @(negedge i_clk);
    checkOutput("load_write_count", got_writes.size() - base_wr, exp.size());
    checkOutput("load_enable", enable_total - base_en, 0);
    for (int i = 0; i < exp.size() && base_wr + i < got_writes.size(); i++) begin
      checkOutput($sformatf("load_addr[%0d]", i), got_writes[base_wr+i][63:32], exp[i][63:32]);
      checkOutput($sformatf("load_word[%0d]", i), got_writes[base_wr+i][31:0], exp[i][31:0]);
    end
    model_loaded = 1'b1;
    model_halted = 1'b0;
    check_flags("load");
  endtask

  task automatic rand_load();
    logic [31:0] prog[$];
    logic [31:0] w;
    int len = $urandom_range(1, 6);
    for (int i = 0; i < len; i++) begin
      w = $urandom;
      if ($urandom_range(0, 2) == 0) w[15:8] = 8'h00;
      if (w == 32'h0) w = 32'h1;
      prog.push_back(w);
    end
    prog.push_back(32'h0);
    do_load(prog);
  endtask

  // Run with HALT reported on the n-th enabled cycle.
  task automatic do_run(input int n);
    int base_en = enable_total;
    bit allowed = model_loaded && !model_halted;
    applyStimulus(B_RUN);
    i_halt = 1'b0;
    for (int k = 1; k <= n; k++) begin
      if (k == n) i_halt = 1'b1;
      @(negedge i_clk);
    end
    i_halt = 1'b0;
    @(negedge i_clk);
    checkOutput("run_enable_cycles", enable_total - base_en, allowed ? n : 0);
    checkOutput("run_enable_low", o_enable, 0);
    if (allowed) model_halted = 1'b1;
    check_flags("run");
  endtask

  task automatic do_step(input bit halt_now);
    int base_en = enable_total;
    bit allowed = model_loaded && !model_halted;
    applyStimulus(B_STEP);
    i_halt = halt_now;
    @(negedge i_clk);
    i_halt = 1'($urandom);
    checkOutput("step_rx_ready", o_rx_ready, 1);
    checkOutput("step_enable_cycles", enable_total - base_en, allowed ? 1 : 0);
    if (allowed && halt_now) model_halted = 1'b1;
    check_flags("step");
  endtask

  task automatic do_garbage();
    logic [7:0] b;
    int base_en = enable_total;
    int base_wr = got_writes.size();
    do b = 8'($urandom); while (b == B_LOAD || b == B_RUN || b == B_STEP);
    applyStimulus(b);
    repeat (2) @(negedge i_clk);
    checkOutput("garbage_enable", enable_total - base_en, 0);
    checkOutput("garbage_write", got_writes.size() - base_wr, 0);
    check_flags("garbage");
  endtask

  task automatic reset_mid_load();
    int base_wr = got_writes.size();
    applyStimulus(B_LOAD);
    applyStimulus(8'($urandom));
    applyStimulus(8'($urandom));
    i_reset = 1'b1;
    repeat (2) @(negedge i_clk);
    check_reset_outputs("rst_load");
    checkOutput("rst_load_no_write", got_writes.size() - base_wr, 0);
    release_reset();
  endtask

  task automatic reset_mid_run();
    rand_load();
    applyStimulus(B_RUN);
    i_halt = 1'b0;
    @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);
    checkOutput("rst_run_enable", o_enable, 0);
    check_reset_outputs("rst_run");
    release_reset();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    logic [31:0] prog[$];
    logic [31:0] w;

    repeat (2) @(negedge i_clk);
    check_reset_outputs("por");
    release_reset();

    // Commands before any program is resident are swallowed.
    do_run(3);
    do_step(1'b0);

    prog.push_back(32'h00223021);
    prog.push_back(32'h00000000);
    do_load(prog);
    do_run(5);

    // After HALT the program may not be restarted without a reload.
    do_run(2);
    do_step(1'b0);

    prog.delete();
    prog.push_back(32'h11111111);
    prog.push_back(32'h22222222);
    prog.push_back(32'h0);
    do_load(prog);
    do_step(1'b0);
    do_step(1'b0);
    do_step(1'b0);
    do_step(1'b1);
    do_step(1'b0);

    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 5))
        0: rand_load();
        1: do_run($urandom_range(1, 8));
        2: do_step(1'($urandom));
        3: do_garbage();
        4: reset_mid_load();
        default: reset_mid_run();
      endcase
    end

    reset_mid_load();
    rand_load();
    do_step(1'b0);

    // A full memory image with no HALT word stops at the last slot.
    prog.delete();
    for (int i = 0; i < MEM_DEPTH; i++) begin
      w = $urandom;
      if (w == 32'h0) w = 32'hDEADBEEF;
      prog.push_back(w);
    end
    do_load(prog);
    do_step(1'b0);
    do_garbage();
    do_run(4);

    checkOutput("write_enable_overlap", overlap_total, 0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
